// File: rtl/pulse_stretch_pkg.sv
// ============================================================================
//  Module  : pulse_stretch_pkg
//  Purpose : Shared state encodings and sizing helpers for pulse_stretch and
//            the status-LED logic that decodes its state.
//  Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

package pulse_stretch_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_HIGH = 2'd1,
        ST_GAP  = 2'd2
    } state_t;

    // Down-counter width; a floor of one bit keeps HOLD=GAP=1 builds legal.
    function automatic int cnt_width(input int hold, input int gap);
        int m;
        m = (hold > gap) ? hold : gap;
        return ($clog2(m) < 1) ? 1 : $clog2(m);
    endfunction

endpackage

`default_nettype wire

// File: rtl/pulse_stretch_cycle_counter.sv
// ============================================================================
//  Module  : pulse_stretch_cycle_counter
//  Purpose : Loadable down-counter with zero flag; holds at zero, never wraps.
//  Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module pulse_stretch_cycle_counter #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_load,
    input  logic [WIDTH-1:0] i_load_val,
    output logic             o_zero
);

    logic [WIDTH-1:0] r_count;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_count <= '0;
        end else if (i_load) begin
            r_count <= i_load_val;
        end else if (r_count != '0) begin
            r_count <= r_count - WIDTH'(1);
        end
    end

    assign o_zero = (r_count == '0);

endmodule

`default_nettype wire

// File: rtl/pulse_stretch.sv
// ============================================================================
//  Module  : pulse_stretch
//  Purpose : Stretches one-cycle event strobes into fixed-width level pulses
//            separated by a minimum gap; strobes arriving mid-pulse are queued.
//            Optional macro PULSE_STRETCH_OVF_EN adds a sticky overflow output.
//  Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module pulse_stretch
    import pulse_stretch_pkg::*;
#(
    parameter  int HOLD_CYCLES = 50_000_000,
    parameter  int GAP_CYCLES  = 25_000_000,
    parameter  int MAX_PENDING = 7,
    localparam int PW          = $clog2(MAX_PENDING + 1)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          in_pulse,
    output logic          out_level,
    output logic          busy,
    output logic [PW-1:0] pending
`ifdef PULSE_STRETCH_OVF_EN
    ,
    output logic          overflow
`endif
);

    localparam int            c_CW      = cnt_width(HOLD_CYCLES, GAP_CYCLES);
    localparam logic [c_CW-1:0] c_HOLD_LD = c_CW'(HOLD_CYCLES - 1);
    localparam logic [c_CW-1:0] c_GAP_LD  = c_CW'(GAP_CYCLES - 1);
    localparam logic [PW-1:0] c_MAX_P   = PW'(MAX_PENDING);

    state_t          r_state;
    state_t          w_state_nxt;
    logic            r_out_level;
    logic [PW-1:0]   r_pending;
    logic [PW-1:0]   w_pending_nxt;
    logic            w_load;
    logic [c_CW-1:0] w_load_val;
    logic            w_zero;
    logic            w_inc;
    logic            w_dec;
    logic            w_full;

    pulse_stretch_cycle_counter #(
        .WIDTH (c_CW)
    ) u_counter (
        .clk        (clk),
        .rst        (rst),
        .i_load     (w_load),
        .i_load_val (w_load_val),
        .o_zero     (w_zero)
    );

    always_comb begin
        w_state_nxt = r_state;
        w_load      = 1'b0;
        w_load_val  = '0;
        w_inc       = 1'b0;
        w_dec       = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (in_pulse) begin
                    w_state_nxt = ST_HIGH;
                    w_load      = 1'b1;
                    w_load_val  = c_HOLD_LD;
                end
            end
            ST_HIGH: begin
                w_inc = in_pulse;
                if (w_zero) begin
                    w_state_nxt = ST_GAP;
                    w_load      = 1'b1;
                    w_load_val  = c_GAP_LD;
                end
            end
            ST_GAP: begin
                w_inc = in_pulse;
                if (w_zero) begin
                    if (r_pending != '0) begin
                        w_state_nxt = ST_HIGH;
                        w_load      = 1'b1;
                        w_load_val  = c_HOLD_LD;
                        w_dec       = 1'b1;
                    end else if (in_pulse) begin
                        // Strobe on the final gap cycle starts the pulse itself.
                        w_state_nxt = ST_HIGH;
                        w_load      = 1'b1;
                        w_load_val  = c_HOLD_LD;
                        w_inc       = 1'b0;
                    end else begin
                        w_state_nxt = ST_IDLE;
                    end
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    assign w_full = (r_pending == c_MAX_P);

    always_comb begin
        w_pending_nxt = r_pending;
        if (w_inc && !w_dec && !w_full) begin
            w_pending_nxt = r_pending + PW'(1);
        end else if (w_dec && !w_inc) begin
            w_pending_nxt = r_pending - PW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= ST_IDLE;
            r_out_level <= 1'b0;
            r_pending   <= '0;
        end else begin
            r_state     <= w_state_nxt;
            r_out_level <= (w_state_nxt == ST_HIGH);
            r_pending   <= w_pending_nxt;
        end
    end

    assign out_level = r_out_level;
    assign busy      = (r_state != ST_IDLE);
    assign pending   = r_pending;

`ifdef PULSE_STRETCH_OVF_EN
    logic w_drop;
    logic r_overflow;

    assign w_drop = w_inc && !w_dec && w_full;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_overflow <= 1'b0;
        end else if (w_drop) begin
            r_overflow <= 1'b1;
        end
    end

    assign overflow = r_overflow;
`endif

endmodule

`default_nettype wire

// File: tb/tb_pulse_stretch.sv
// ============================================================================
//  Module  : tb_pulse_stretch
//  Purpose : Self-checking bench for pulse_stretch (HOLD=4, GAP=2, MAX=3).
//  Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_pulse_stretch;

    localparam int H    = 4;
    localparam int G    = 2;
    localparam int MAXP = 3;
    localparam int PW   = $clog2(MAXP + 1);

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          in_pulse = 1'b0;
    logic          out_level;
    logic          busy;
    logic [PW-1:0] pending;
`ifdef PULSE_STRETCH_OVF_EN
    logic          overflow;
    logic          m_ovf;
`endif

    int n_tests = 0;
    int n_fail  = 0;
    int cyc     = 0;

    // Reference model: each accepted event is (strobe cycle, rise cycle).
    int ev_t[$];
    int ev_r[$];
    int last_rise;

    pulse_stretch #(
        .HOLD_CYCLES (H),
        .GAP_CYCLES  (G),
        .MAX_PENDING (MAXP)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .in_pulse  (in_pulse),
        .out_level (out_level),
        .busy      (busy),
        .pending   (pending)
`ifdef PULSE_STRETCH_OVF_EN
        ,
        .overflow  (overflow)
`endif
    );

    always #5 clk = ~clk;

    function automatic logic m_out(input int c);
        foreach (ev_r[i]) if (ev_r[i] <= c && c <= ev_r[i] + H - 1) return 1'b1;
        return 1'b0;
    endfunction

    function automatic logic m_busy(input int c);
        foreach (ev_r[i]) if (ev_t[i] < c && c <= ev_r[i] + H + G - 1) return 1'b1;
        return 1'b0;
    endfunction

    function automatic int m_pend(input int c);
        int n = 0;
        foreach (ev_r[i]) if (ev_t[i] < c && ev_r[i] > c) n++;
        return n;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s cycle=%0d observed=%0h expected=%0h", tag, cyc, obs, exp);
        end
    endtask

    task automatic model_apply(input logic r, input logic p, input int c);
        int rise;
        int cnt;
        if (r) begin
            ev_t.delete();
            ev_r.delete();
            last_rise = -1000;
`ifdef PULSE_STRETCH_OVF_EN
            m_ovf = 1'b0;
`endif
        end else if (p) begin
            rise = (c + 1 > last_rise + H + G) ? c + 1 : last_rise + H + G;
            cnt = 0;
            foreach (ev_r[i]) if (ev_r[i] > c + 1) cnt++;
            if (rise > c + 1 && cnt >= MAXP) begin
`ifdef PULSE_STRETCH_OVF_EN
                m_ovf = 1'b1;
`endif
            end else begin
                ev_t.push_back(c);
                ev_r.push_back(rise);
                last_rise = rise;
            end
        end
    endtask

    // One clock: check outputs for this cycle, then present inputs for its edge.
    task automatic step(input logic r, input logic p);
        @(negedge clk);
        if (cyc > 0) begin
            chk("out_level", 32'(out_level), 32'(m_out(cyc)));
            chk("busy",      32'(busy),      32'(m_busy(cyc)));
            chk("pending",   32'(pending),   32'(m_pend(cyc)));
`ifdef PULSE_STRETCH_OVF_EN
            chk("overflow",  32'(overflow),  32'(m_ovf));
`endif
        end
        model_apply(r, p, cyc);
        rst      = r;
        in_pulse = p;
        cyc++;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 1'b0);
    endtask

    initial begin
        last_rise = -1000;
`ifdef PULSE_STRETCH_OVF_EN
        m_ovf = 1'b0;
`endif
        step(1'b1, 1'b0);
        step(1'b1, 1'b0);
        idle(8);

        // Single strobe
        step(1'b0, 1'b1);
        idle(12);

        // Two strobes two cycles apart
        step(1'b0, 1'b1);
        idle(1);
        step(1'b0, 1'b1);
        idle(16);

        // Five strobes across one HIGH phase: saturates and drops one
        repeat (5) step(1'b0, 1'b1);
        idle(40);

        // Strobe on the last gap cycle with nothing queued
        step(1'b0, 1'b1);
        idle(5);
        step(1'b0, 1'b1);
        idle(14);

        // Same, but with two queued events
        repeat (3) step(1'b0, 1'b1);
        idle(3);
        step(1'b0, 1'b1);
        idle(30);

        // Reset mid-HIGH with two queued
        repeat (3) step(1'b0, 1'b1);
        step(1'b1, 1'b0);
        idle(15);

        // Randomized traffic with occasional resets
        repeat (600) step($urandom_range(0, 99) < 2, $urandom_range(0, 99) < 35);
        idle(40);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
